seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_scan_ctrl_hex_seg.sv | 11 +
 rtl/seg_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment patterns are active low, ordered {a,b,c,d,e,f,g,dp}.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam int         NUM_DIGITS = 4;

    // Indexed by hex value; element 0 is the rightmost entry of the literal.
    localparam logic [15:0][7:0] HEX_SEG_TABLE = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    typedef enum logic {
        SHOW_OP  = 1'b0,
        SHOW_RES = 1'b1
    } mode_t;

endpackage

// File: rtl/seg_scan_ctrl_hex_seg.sv
// Combinational hex nibble to seven-segment decoder (active low, dp off).
module hex_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode display scanner that shows either the op mnemonic
// or a held ALU result, switching the shown word only on frame boundaries.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int HOLD_FRAMES  = 500
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_op_word,
    input  logic [15:0] i_result,
    input  logic        i_result_valid,
    output logic [3:0]  o_an,
    output logic [7:0]  o_seg,
    output logic        o_showing_result
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    mode_t         r_mode;
    logic [HW-1:0] r_hold;
    logic [15:0]   r_res;
    logic [31:0]   r_word;
    logic [2:0]    r_op_q;
    logic          r_first;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;

    logic          w_wrap;
    logic          w_frame_end;
    logic          w_op_chg;
    mode_t         w_mode_next;
    logic [HW-1:0] w_hold_next;
    logic [15:0]   w_res_next;
    logic [31:0]   w_res_word;

    assign w_wrap      = (r_cnt == CNT_MAX);
    assign w_frame_end = w_wrap && (r_idx == 2'd3);
    assign w_op_chg    = (i_op != r_op_q);

    // Priority: op change, then a new result, then hold expiry at frame end.
    always_comb begin
        w_mode_next = r_mode;
        w_hold_next = r_hold;
        w_res_next  = r_res;
        if (w_op_chg) begin
            w_mode_next = SHOW_OP;
            w_hold_next = '0;
        end else if (i_result_valid) begin
            w_mode_next = SHOW_RES;
            w_hold_next = '0;
            w_res_next  = i_result;
        end else if ((r_mode == SHOW_RES) && w_frame_end) begin
            if (r_hold == HOLD_LAST) begin
                w_mode_next = SHOW_OP;
                w_hold_next = '0;
            end else begin
                w_hold_next = r_hold + 1'b1;
            end
        end
    end

    // Decode the post-update result so a result arriving on a frame end shows at once.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
        hex_seg u_hex_seg (
            .i_nibble (w_res_next[4*g +: 4]),
            .o_seg    (w_res_word[8*g +: 8])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_op_q <= '0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            r_op_q <= i_op;
            if (w_wrap) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode <= SHOW_OP;
            r_hold <= '0;
            r_res  <= '0;
        end else begin
            r_mode <= w_mode_next;
            r_hold <= w_hold_next;
            r_res  <= w_res_next;
        end
    end

    // The word only changes between frames so a frame is never torn.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word  <= 32'hFFFF_FFFF;
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (r_first || w_frame_end) begin
                r_word <= (w_mode_next == SHOW_OP) ? i_op_word : w_res_word;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
        end else if (r_cnt < BLANK_LIM) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= r_word[{r_idx, 3'b000} +: 8];
        end
    end

    assign o_an             = r_an;
    assign o_seg            = r_seg;
    assign o_showing_result = (r_mode == SHOW_RES);

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: scan table, hand-written mode
// sequences, async reset, and randomized traffic against a cycle-count model.
module tb_seg_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int HF = 3;
    localparam int FRAME = RD * 4;

    localparam logic [31:0] W0 = 32'hFF11_D585;
    localparam logic [31:0] W4 = 32'h6171_C1FF;
    localparam logic [31:0] W5 = 32'h4911_71FF;

    logic        clk = 1'b0;
    logic        rstN;
    logic [2:0]  op;
    logic [31:0] opWord;
    logic [15:0] result;
    logic        resultValid;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        showingResult;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .HOLD_FRAMES  (HF)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rstN),
        .i_op             (op),
        .i_op_word        (opWord),
        .i_result         (result),
        .i_result_valid   (resultValid),
        .o_an             (an),
        .o_seg            (seg),
        .o_showing_result (showingResult)
    );

    int total = 0;
    int bad   = 0;

    // Model state: time since reset release plus the displayed word and mode.
    int          cyc;
    logic [31:0] mWord;
    logic        mShow;
    int          mHold;
    logic [15:0] mRes;
    logic [2:0]  mOpQ;
    logic        mFirst;

    logic [2:0]  curOp;
    logic [31:0] curWord;

    typedef struct {
        int         clkIdx;
        logic [3:0] an;
        logic [7:0] seg;
    } scanVec_t;

    scanVec_t scanTable [14];

    function automatic logic [7:0] hexSeg(input logic [3:0] n);
        case (n)
            4'h0: return 8'h03;  4'h1: return 8'h9F;  4'h2: return 8'h25;  4'h3: return 8'h0D;
            4'h4: return 8'h99;  4'h5: return 8'h49;  4'h6: return 8'h41;  4'h7: return 8'h1F;
            4'h8: return 8'h01;  4'h9: return 8'h09;  4'hA: return 8'h11;  4'hB: return 8'hC1;
            4'hC: return 8'h63;  4'hD: return 8'h85;  4'hE: return 8'h61;  default: return 8'h71;
        endcase
    endfunction

    function automatic logic [31:0] hexWord(input logic [15:0] r);
        return {hexSeg(r[15:12]), hexSeg(r[11:8]), hexSeg(r[7:4]), hexSeg(r[3:0])};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        cyc    = 0;
        mWord  = 32'hFFFF_FFFF;
        mShow  = 1'b0;
        mHold  = 0;
        mRes   = 16'h0000;
        mOpQ   = 3'd0;
        mFirst = 1'b1;
    endtask

    // One clock: drive inputs, predict from the pre-edge state, advance, compare.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] w,
                                 input logic [15:0] r, input logic v);
        int          pos;
        int          idx;
        bit          frameEnd;
        logic        nShow;
        int          nHold;
        logic [15:0] nRes;
        logic [3:0]  expAn;
        logic [7:0]  expSeg;
        op = o; opWord = w; result = r; resultValid = v;
        pos = cyc % RD;
        idx = (cyc / RD) % 4;
        if (pos < BC) begin
            expAn  = 4'hF;
            expSeg = 8'hFF;
        end else begin
            expAn  = 4'hF & ~(4'h1 << idx);
            expSeg = mWord[8*idx +: 8];
        end
        frameEnd = ((cyc % FRAME) == FRAME - 1);
        nShow = mShow; nHold = mHold; nRes = mRes;
        if (o != mOpQ) begin
            nShow = 1'b0; nHold = 0;
        end else if (v) begin
            nShow = 1'b1; nHold = 0; nRes = r;
        end else if (mShow && frameEnd) begin
            nHold = mHold + 1;
            if (nHold == HF) begin
                nShow = 1'b0; nHold = 0;
            end
        end
        if (mFirst || frameEnd) mWord = nShow ? hexWord(nRes) : w;
        mFirst = 1'b0;
        mShow = nShow; mHold = nHold; mRes = nRes; mOpQ = o;
        cyc++;
        @(posedge clk);
        #1;
        resultValid = 1'b0;
        checkOutput("model_an", {28'h0, an}, {28'h0, expAn});
        checkOutput("model_seg", {24'h0, seg}, {24'h0, expSeg});
        checkOutput("model_showing", {31'h0, showingResult}, {31'h0, mShow});
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(curOp, curWord, 16'h0000, 1'b0);
    endtask

    task automatic waitFrameEnd();
        int k;
        k = 0;
        do begin
            runIdle(1);
            k++;
        end while (((cyc % FRAME) != 0) && (k < FRAME + 2));
        if ((cyc % FRAME) != 0) checkOutput("frame_end_timeout", 32'd1, 32'd0);
    endtask

    // Call right after a frame end: samples each digit's first enabled clock.
    task automatic checkDigits(input string name, input logic [31:0] word);
        runIdle(3);
        checkOutput({name, "_an0"}, {28'h0, an}, 32'hE);
        checkOutput({name, "_seg0"}, {24'h0, seg}, {24'h0, word[7:0]});
        runIdle(8);
        checkOutput({name, "_an1"}, {28'h0, an}, 32'hD);
        checkOutput({name, "_seg1"}, {24'h0, seg}, {24'h0, word[15:8]});
        runIdle(8);
        checkOutput({name, "_an2"}, {28'h0, an}, 32'hB);
        checkOutput({name, "_seg2"}, {24'h0, seg}, {24'h0, word[23:16]});
        runIdle(8);
        checkOutput({name, "_an3"}, {28'h0, an}, 32'h7);
        checkOutput({name, "_seg3"}, {24'h0, seg}, {24'h0, word[31:24]});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] opWords [8];
        int          k;

        scanTable[0]  = '{1,  4'hF, 8'hFF};
        scanTable[1]  = '{2,  4'hF, 8'hFF};
        scanTable[2]  = '{3,  4'hE, 8'h85};
        scanTable[3]  = '{8,  4'hE, 8'h85};
        scanTable[4]  = '{9,  4'hF, 8'hFF};
        scanTable[5]  = '{10, 4'hF, 8'hFF};
        scanTable[6]  = '{11, 4'hD, 8'hD5};
        scanTable[7]  = '{16, 4'hD, 8'hD5};
        scanTable[8]  = '{19, 4'hB, 8'h11};
        scanTable[9]  = '{24, 4'hB, 8'h11};
        scanTable[10] = '{27, 4'h7, 8'hFF};
        scanTable[11] = '{32, 4'h7, 8'hFF};
        scanTable[12] = '{33, 4'hF, 8'hFF};
        scanTable[13] = '{35, 4'hE, 8'h85};

        rstN = 1'b1; op = 3'd0; opWord = W0; result = 16'h0; resultValid = 1'b0;
        curOp = 3'd0; curWord = W0;
        #2 rstN = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("reset_an", {28'h0, an}, 32'hF);
        checkOutput("reset_seg", {24'h0, seg}, 32'hFF);
        checkOutput("reset_showing", {31'h0, showingResult}, 32'h0);
        rstN = 1'b1;
        modelReset();

        // Reset scan against hand-derived table.
        for (int c = 1; c <= 40; c++) begin
            runIdle(1);
            for (int j = 0; j < 14; j++) begin
                if (scanTable[j].clkIdx == c) begin
                    checkOutput($sformatf("scan%0d_an", c), {28'h0, an}, {28'h0, scanTable[j].an});
                    checkOutput($sformatf("scan%0d_seg", c), {24'h0, seg}, {24'h0, scanTable[j].seg});
                end
            end
        end

        // Result display and hold expiry.
        applyStimulus(curOp, curWord, 16'h12AF, 1'b1);
        checkOutput("res_showing_on", {31'h0, showingResult}, 32'h1);
        waitFrameEnd();
        checkDigits("res12af", 32'h9F25_1171);
        waitFrameEnd();
        checkOutput("res_hold_fe2", {31'h0, showingResult}, 32'h1);
        waitFrameEnd();
        checkOutput("res_hold_fe3", {31'h0, showingResult}, 32'h0);
        checkDigits("res_revert", W0);

        // Re-trigger during hold frame 2.
        applyStimulus(curOp, curWord, 16'h12AF, 1'b1);
        waitFrameEnd();
        waitFrameEnd();
        runIdle(5);
        applyStimulus(curOp, curWord, 16'h0003, 1'b1);
        waitFrameEnd();
        checkDigits("retrig0003", 32'h0303_030D);
        checkOutput("retrig_fe1", {31'h0, showingResult}, 32'h1);
        waitFrameEnd();
        checkOutput("retrig_fe2", {31'h0, showingResult}, 32'h1);
        waitFrameEnd();
        checkOutput("retrig_fe3", {31'h0, showingResult}, 32'h0);

        // Op change beats a coincident result.
        curOp = 3'd4; curWord = W4;
        runIdle(4);
        applyStimulus(curOp, curWord, 16'h1234, 1'b1);
        runIdle(3);
        checkOutput("ovr_pre_showing", {31'h0, showingResult}, 32'h1);
        curOp = 3'd5; curWord = W5;
        applyStimulus(curOp, curWord, 16'hBEEF, 1'b1);
        checkOutput("ovr_showing_off", {31'h0, showingResult}, 32'h0);
        waitFrameEnd();
        checkDigits("ovr_word", W5);

        // Asynchronous reset while a digit is lit.
        applyStimulus(curOp, curWord, 16'h5A5A, 1'b1);
        k = 0;
        while ((an == 4'hF) && (k < 20)) begin
            runIdle(1);
            k++;
        end
        checkOutput("arst_pre_an_lit", {31'h0, (an != 4'hF)}, 32'h1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("arst_an", {28'h0, an}, 32'hF);
        checkOutput("arst_seg", {24'h0, seg}, 32'hFF);
        checkOutput("arst_showing", {31'h0, showingResult}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rstN = 1'b1;
        modelReset();
        runIdle(1);
        checkOutput("arst_rel1_an", {28'h0, an}, 32'hF);
        runIdle(1);
        checkOutput("arst_rel2_an", {28'h0, an}, 32'hF);
        runIdle(1);
        checkOutput("arst_rel3_an", {28'h0, an}, 32'hE);
        checkOutput("arst_rel3_seg", {24'h0, seg}, {24'h0, W5[7:0]});

        // Randomized traffic, alternating busy and quiet stretches.
        for (int i = 0; i < 8; i++) opWords[i] = $urandom;
        for (int i = 0; i < 3000; i++) begin
            logic v;
            if ($urandom_range(0, 79) == 0) begin
                curOp   = 3'($urandom_range(0, 7));
                curWord = opWords[curOp];
            end
            if (((i / 500) % 2) == 0) v = ($urandom_range(0, 14) == 0);
            else                      v = ($urandom_range(0, 199) == 0);
            applyStimulus(curOp, curWord, 16'($urandom), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
